// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the responder FSM state type.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_e;

    // Little-endian byte lanes touched by a legal transfer.
    function automatic logic [3:0] byte_en(input logic [1:0] off, input logic [1:0] size);
        logic [3:0] be;
        if (size == 2'(HSIZE_BYTE)) begin
            be = 4'b0001 << off;
        end else if (size == 2'(HSIZE_HALF)) begin
            be = off[1] ? 4'b1100 : 4'b0011;
        end else begin
            be = 4'b1111;
        end
        return be;
    endfunction

endpackage

// File: rtl/ahb_slave_mem_if.sv
// AHB-Lite responder-side signal bundle.
interface ahb_slave_mem_if;

    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        input  hreadyout, hresp, hrdata
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        output hreadyout, hresp, hrdata
    );

endinterface

// File: rtl/ahb_bytemem.sv
// DEPTH x 32 storage with a byte-enable write port and an asynchronous read port.
module ahb_bytemem #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic [3:0]       be_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [31:0]      wdata_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [DEPTH];

    // Contents survive reset, so the array has no reset branch.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (be_i[b]) begin
                mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite word-addressed memory responder with programmable wait states
// and a two-cycle ERROR response.
module ahb_slave_mem
    import ahb_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic          hclk,
    input  logic          hreset,
    ahb_slave_mem_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    state_e           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [1:0]       off_q, off_d;
    logic [1:0]       size_q, size_d;
    logic             write_q, write_d;
    logic             hreadyout_q, hreadyout_d;
    logic             hresp_q, hresp_d;
    logic [31:0]      hrdata_q, hrdata_d;

    logic             accept_c;
    logic             err_c;
    logic [IDX_W-1:0] req_idx_c;
    logic [IDX_W-1:0] rd_idx_c;
    logic             commit_c;
    logic [3:0]       be_c;
    logic [31:0]      mem_rdata_c;
    logic [31:0]      fwd_word_c;

    assign accept_c = bus.hsel & bus.hready
                    & ((bus.htrans == HTRANS_NONSEQ) | (bus.htrans == HTRANS_SEQ))
                    & ((state_q == ST_IDLE) | (state_q == ST_ERR2));

    assign err_c = (bus.hsize > HSIZE_WORD)
                 | ((bus.hsize == HSIZE_HALF) & bus.haddr[0])
                 | ((bus.hsize == HSIZE_WORD) & (|bus.haddr[1:0]))
                 | (bus.haddr[31:2] >= 30'(DEPTH));

    assign req_idx_c = bus.haddr[IDX_W+1:2];

    // A read completing out of WAIT uses the held index; otherwise it is the new address.
    assign rd_idx_c = (state_q == ST_WAIT) ? idx_q : req_idx_c;

    // done_q marks the completion cycle of an OKAY data phase.
    assign commit_c = done_q & write_q & ~hreset;
    assign be_c     = byte_en(off_q, size_q) & {4{commit_c}};

    ahb_bytemem #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_mem (
        .clk     (hclk),
        .be_i    (be_c),
        .waddr_i (idx_q),
        .wdata_i (bus.hwdata),
        .raddr_i (rd_idx_c),
        .rdata_o (mem_rdata_c)
    );

    // Merge bytes committing this edge into a same-word read.
    always_comb begin
        fwd_word_c = mem_rdata_c;
        if (idx_q == rd_idx_c) begin
            for (int b = 0; b < 4; b++) begin
                if (be_c[b]) begin
                    fwd_word_c[8*b +: 8] = bus.hwdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            done_q      <= 1'b0;
            idx_q       <= '0;
            off_q       <= 2'd0;
            size_q      <= 2'd0;
            write_q     <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            hrdata_q    <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            idx_q       <= idx_d;
            off_q       <= off_d;
            size_q      <= size_d;
            write_q     <= write_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            hrdata_q    <= hrdata_d;
        end
    end

    // Next-state and next-cycle response.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        idx_d       = idx_q;
        off_d       = off_q;
        size_d      = size_q;
        write_d     = write_q;
        hreadyout_d = 1'b1;
        hresp_d     = HRESP_OKAY;
        hrdata_d    = hrdata_q;

        unique case (state_q)
            ST_WAIT: begin
                cnt_d       = cnt_q - 3'd1;
                hreadyout_d = 1'b0;
                if (cnt_q == 3'd1) begin
                    state_d     = ST_IDLE;
                    done_d      = 1'b1;
                    hreadyout_d = 1'b1;
                    if (!write_q) begin
                        hrdata_d = fwd_word_c;
                    end
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
                hresp_d = HRESP_ERROR;
            end
            default: begin
                state_d = ST_IDLE;
                if (accept_c) begin
                    idx_d   = req_idx_c;
                    off_d   = bus.haddr[1:0];
                    size_d  = bus.hsize[1:0];
                    write_d = bus.hwrite;
                    if (err_c) begin
                        state_d     = ST_ERR1;
                        hreadyout_d = 1'b0;
                        hresp_d     = HRESP_ERROR;
                    end else if (WAIT_STATES == 0) begin
                        done_d = 1'b1;
                        if (!bus.hwrite) begin
                            hrdata_d = fwd_word_c;
                        end
                    end else begin
                        state_d     = ST_WAIT;
                        cnt_d       = 3'(WAIT_STATES);
                        hreadyout_d = 1'b0;
                    end
                end
            end
        endcase
    end

    assign bus.hreadyout = hreadyout_q;
    assign bus.hresp     = hresp_q;
    assign bus.hrdata    = hrdata_q;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem: one zero-wait and one 3-wait instance.
module tb_ahb_slave_mem;

    logic hclk = 1'b0;
    logic hreset;
    int   total = 0;
    int   bad   = 0;

    always #5 hclk = ~hclk;

    ahb_slave_mem_if b0 ();
    ahb_slave_mem_if b3 ();

    assign b0.hready = b0.hreadyout;
    assign b3.hready = b3.hreadyout;

    ahb_slave_mem #(.DEPTH(16), .WAIT_STATES(0)) dut0 (.hclk(hclk), .hreset(hreset), .bus(b0.slave));
    ahb_slave_mem #(.DEPTH(16), .WAIT_STATES(3)) dut3 (.hclk(hclk), .hreset(hreset), .bus(b3.slave));

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic aphase0(input logic w, input logic [31:0] a, input logic [2:0] sz);
        b0.hsel = 1'b1; b0.htrans = 2'b10; b0.hwrite = w; b0.haddr = a; b0.hsize = sz;
    endtask

    task automatic idle0();
        b0.hsel = 1'b0; b0.htrans = 2'b00;
    endtask

    task automatic aphase3(input logic w, input logic [31:0] a, input logic [2:0] sz);
        b3.hsel = 1'b1; b3.htrans = 2'b10; b3.hwrite = w; b3.haddr = a; b3.hsize = sz;
    endtask

    task automatic idle3();
        b3.hsel = 1'b0; b3.htrans = 2'b00;
    endtask

    task automatic test_reset();
        hreset = 1'b1;
        idle0(); idle3();
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (b0.hreadyout !== 1'b1 || b0.hresp !== 1'b0 || b0.hrdata !== 32'd0) begin
                bad++;
                $display("FAIL reset0 cyc%0d rdy=%b resp=%b rdata=%h want 1 0 0", i, b0.hreadyout, b0.hresp, b0.hrdata);
            end
            total++;
            if (b3.hreadyout !== 1'b1 || b3.hresp !== 1'b0 || b3.hrdata !== 32'd0) begin
                bad++;
                $display("FAIL reset3 cyc%0d rdy=%b resp=%b rdata=%h want 1 0 0", i, b3.hreadyout, b3.hresp, b3.hrdata);
            end
        end
        hreset = 1'b0;
        tick();
        total++;
        if (b0.hreadyout !== 1'b1 || b0.hresp !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset rdy=%b resp=%b want 1 0", b0.hreadyout, b0.hresp);
        end
    endtask

    task automatic test_word_rw();
        aphase0(1'b1, 32'h4, 3'd2);
        tick();
        total++;
        if (b0.hreadyout !== 1'b1 || b0.hresp !== 1'b0) begin
            bad++;
            $display("FAIL word_wr_ready rdy=%b resp=%b want 1 0", b0.hreadyout, b0.hresp);
        end
        b0.hwdata = 32'hDEADBEEF;
        idle0();
        tick();
        total++;
        if (b0.hrdata !== 32'd0) begin
            bad++;
            $display("FAIL rdata_hold_on_write got=%h want=00000000", b0.hrdata);
        end
        aphase0(1'b0, 32'h4, 3'd2);
        tick();
        idle0();
        total++;
        if (b0.hreadyout !== 1'b1 || b0.hrdata !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL word_rd rdy=%b rdata=%h want 1 deadbeef", b0.hreadyout, b0.hrdata);
        end
        tick();
    endtask

    task automatic test_lanes();
        aphase0(1'b1, 32'h8, 3'd2);
        tick();
        b0.hwdata = 32'h0000_0000;
        aphase0(1'b1, 32'h9, 3'd0);
        tick();
        b0.hwdata = 32'h0000_AB00;
        aphase0(1'b1, 32'hA, 3'd1);
        tick();
        b0.hwdata = 32'h1234_0000;
        aphase0(1'b0, 32'h8, 3'd2);
        tick();
        total++;
        if (b0.hrdata !== 32'h1234AB00) begin
            bad++;
            $display("FAIL lanes_fwd got=%h want=1234ab00", b0.hrdata);
        end
        idle0();
        tick();
        aphase0(1'b0, 32'h8, 3'd2);
        tick();
        idle0();
        total++;
        if (b0.hrdata !== 32'h1234AB00) begin
            bad++;
            $display("FAIL lanes_reread got=%h want=1234ab00", b0.hrdata);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        aphase0(1'b1, 32'hC, 3'd2);
        tick();
        b0.hwdata = 32'h1111_1111;
        aphase0(1'b0, 32'hC, 3'd2);
        tick();
        idle0();
        total++;
        if (b0.hreadyout !== 1'b1 || b0.hrdata !== 32'h11111111) begin
            bad++;
            $display("FAIL b2b_fwd rdy=%b rdata=%h want 1 11111111", b0.hreadyout, b0.hrdata);
        end
        tick();
    endtask

    task automatic test_errors();
        logic [31:0] bad_addr [2];
        bad_addr[0] = 32'h2;
        bad_addr[1] = 32'h40;
        aphase0(1'b1, 32'h0, 3'd2);
        tick();
        b0.hwdata = 32'hA5A5A5A5;
        idle0();
        tick();
        for (int k = 0; k < 2; k++) begin
            aphase0(1'b1, bad_addr[k], 3'd2);
            tick();
            idle0();
            b0.hwdata = 32'hFFFF_FFFF;
            total++;
            if (b0.hresp !== 1'b1 || b0.hreadyout !== 1'b0) begin
                bad++;
                $display("FAIL err1 addr=%h resp=%b rdy=%b want 1 0", bad_addr[k], b0.hresp, b0.hreadyout);
            end
            tick();
            total++;
            if (b0.hresp !== 1'b1 || b0.hreadyout !== 1'b1) begin
                bad++;
                $display("FAIL err2 addr=%h resp=%b rdy=%b want 1 1", bad_addr[k], b0.hresp, b0.hreadyout);
            end
            tick();
            total++;
            if (b0.hresp !== 1'b0 || b0.hreadyout !== 1'b1) begin
                bad++;
                $display("FAIL err_exit addr=%h resp=%b rdy=%b want 0 1", bad_addr[k], b0.hresp, b0.hreadyout);
            end
        end
        aphase0(1'b0, 32'h0, 3'd2);
        tick();
        idle0();
        total++;
        if (b0.hrdata !== 32'hA5A5A5A5) begin
            bad++;
            $display("FAIL err_no_commit got=%h want=a5a5a5a5", b0.hrdata);
        end
        tick();
        aphase0(1'b0, 32'h4, 3'd3);
        tick();
        idle0();
        total++;
        if (b0.hresp !== 1'b1 || b0.hreadyout !== 1'b0 || b0.hrdata !== 32'hA5A5A5A5) begin
            bad++;
            $display("FAIL err_hsize resp=%b rdy=%b rdata=%h want 1 0 a5a5a5a5", b0.hresp, b0.hreadyout, b0.hrdata);
        end
        tick();
        tick();
    endtask

    task automatic test_wait_states();
        int lows;
        aphase3(1'b1, 32'h0, 3'd2);
        tick();
        idle3();
        b3.hwdata = 32'hCAFEF00D;
        lows = 0;
        for (int i = 0; i < 8 && b3.hreadyout !== 1'b1; i++) begin
            lows++;
            tick();
        end
        total++;
        if (lows != 3 || b3.hreadyout !== 1'b1) begin
            bad++;
            $display("FAIL ws_write lows=%0d rdy=%b want 3 1", lows, b3.hreadyout);
        end
        tick();
        aphase3(1'b0, 32'h0, 3'd2);
        tick();
        idle3();
        lows = 0;
        for (int i = 0; i < 8 && b3.hreadyout !== 1'b1; i++) begin
            lows++;
            tick();
        end
        total++;
        if (lows != 3 || b3.hreadyout !== 1'b1 || b3.hrdata !== 32'hCAFEF00D) begin
            bad++;
            $display("FAIL ws_read lows=%0d rdy=%b rdata=%h want 3 1 cafef00d", lows, b3.hreadyout, b3.hrdata);
        end
        tick();
    endtask

    task automatic test_reset_in_wait();
        int lows;
        aphase3(1'b1, 32'h0, 3'd2);
        tick();
        idle3();
        b3.hwdata = 32'h12345678;
        total++;
        if (b3.hreadyout !== 1'b0) begin
            bad++;
            $display("FAIL rst_wait_entry rdy=%b want 0", b3.hreadyout);
        end
        tick();
        hreset = 1'b1;
        tick();
        hreset = 1'b0;
        total++;
        if (b3.hreadyout !== 1'b1 || b3.hresp !== 1'b0 || b3.hrdata !== 32'd0) begin
            bad++;
            $display("FAIL rst_in_wait rdy=%b resp=%b rdata=%h want 1 0 0", b3.hreadyout, b3.hresp, b3.hrdata);
        end
        for (int i = 0; i < 5; i++) tick();
        aphase3(1'b0, 32'h0, 3'd2);
        tick();
        idle3();
        lows = 0;
        for (int i = 0; i < 8 && b3.hreadyout !== 1'b1; i++) begin
            lows++;
            tick();
        end
        total++;
        if (lows != 3 || b3.hrdata !== 32'hCAFEF00D) begin
            bad++;
            $display("FAIL rst_no_commit lows=%0d rdata=%h want 3 cafef00d", lows, b3.hrdata);
        end
        tick();
    endtask

    initial begin
        hreset = 1'b1;
        b0.hsel = 1'b0; b0.htrans = 2'b00; b0.hwrite = 1'b0; b0.haddr = 32'd0; b0.hsize = 3'd2; b0.hwdata = 32'd0;
        b3.hsel = 1'b0; b3.htrans = 2'b00; b3.hwrite = 1'b0; b3.haddr = 32'd0; b3.hsize = 3'd2; b3.hwdata = 32'd0;
        test_reset();
        test_word_rw();
        test_lanes();
        test_back_to_back();
        test_errors();
        test_wait_states();
        test_reset_in_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
